// File: rtl/unpooler_pkg.sv
// Shared constants and sizing helpers for the nearest-neighbour upsampler.
package unpooler_pkg;

  localparam logic [8:0] M_DEFAULT = 9'h00c;
  localparam logic [8:0] P_DEFAULT = 9'h003;
  localparam int         N_DEFAULT = 16;

  // Counter width for a 0..v-1 counter, never narrower than one bit.
  function automatic int cnt_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // Pooled map side: number of distinct input columns/rows per map.
  function automatic int mp_of(input logic [8:0] m, input logic [8:0] p);
    return int'(m) / int'(p);
  endfunction

  // Geometry is legal when the block side divides the output side.
  function automatic bit geom_ok(input logic [8:0] m, input logic [8:0] p);
    return (p != 9'd0) && ((int'(m) % int'(p)) == 0) && (m != 9'd0);
  endfunction

endpackage

// File: rtl/unpooler_row_buffer.sv
// MP-deep circular shift register holding one pooled row for replay.
module row_buffer #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         rotate,
  input  logic [W-1:0] d,
  output logic [W-1:0] head
);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;

  // Shift toward the head; the tail takes new data on push or the old head on rotate.
  always_comb begin
    mem_d = mem_q;
    if (push || rotate) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = push ? d : mem_q[0];
    end
  end

  // Storage register, cleared by the block reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  assign head = mem_q[0];

endmodule

// File: rtl/unpooler.sv
// Nearest-neighbour upsampler: replicates each pooled value over a p x p block.
module unpooler
  import unpooler_pkg::*;
#(
  parameter logic [8:0] m = M_DEFAULT,
  parameter logic [8:0] p = P_DEFAULT,
  parameter int         N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         master_rst,
  input  logic         ce,
  input  logic [N-1:0] data_in,
  input  logic         valid_ip,
  output logic         ready_ip,
  output logic [N-1:0] data_out,
  output logic         valid_op,
  output logic         end_op
);

  localparam int P  = int'(p);
  localparam int MP = mp_of(m, p);
  localparam int HW = cnt_w(P);
  localparam int CW = cnt_w(MP);
  localparam logic [HW-1:0] H_LAST = HW'(P - 1);
  localparam logic [CW-1:0] C_LAST = CW'(MP - 1);

  if (!geom_ok(m, p)) begin : g_bad_geom
    $error("unpooler: m must be a nonzero multiple of p");
  end

  // Counters name the next output slot.
  logic [CW-1:0] col_q, col_d, prow_q, prow_d;
  logic [HW-1:0] hrep_q, hrep_d, vrep_q, vrep_d;
  logic [N-1:0]  data_out_q, data_out_d;
  logic          valid_op_q, valid_op_d;
  logic          end_op_q, end_op_d;

  logic          live, accept, emit, rotate, last_slot;
  logic [N-1:0]  head;

  // Slot decode: live row takes input at hrep 0, replay rows stream the buffer.
  always_comb begin
    live      = (vrep_q == '0);
    ready_ip  = ce && live && (hrep_q == '0);
    accept    = valid_ip && ready_ip;
    emit      = ce && (!live || (hrep_q != '0) || accept);
    rotate    = ce && !live && (hrep_q == H_LAST);
    last_slot = (prow_q == C_LAST) && (vrep_q == H_LAST) &&
                (col_q == C_LAST) && (hrep_q == H_LAST);
  end

  // Output next-state: a bubble drops valid but keeps data; ce low holds everything.
  always_comb begin
    data_out_d = data_out_q;
    valid_op_d = valid_op_q;
    end_op_d   = end_op_q;
    if (ce) begin
      valid_op_d = emit;
      end_op_d   = emit && last_slot;
      if (emit) data_out_d = !live ? head : (accept ? data_in : data_out_q);
    end
  end

  // Counter advance on each emitted output: hrep -> col -> vrep -> prow -> wrap.
  always_comb begin
    hrep_d = hrep_q;
    col_d  = col_q;
    vrep_d = vrep_q;
    prow_d = prow_q;
    if (emit) begin
      if (hrep_q != H_LAST) hrep_d = hrep_q + 1'b1;
      else begin
        hrep_d = '0;
        if (col_q != C_LAST) col_d = col_q + 1'b1;
        else begin
          col_d = '0;
          if (vrep_q != H_LAST) vrep_d = vrep_q + 1'b1;
          else begin
            vrep_d = '0;
            prow_d = (prow_q != C_LAST) ? prow_q + 1'b1 : '0;
          end
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      col_q      <= '0;
      prow_q     <= '0;
      hrep_q     <= '0;
      vrep_q     <= '0;
      data_out_q <= '0;
      valid_op_q <= 1'b0;
      end_op_q   <= 1'b0;
    end else begin
      col_q      <= col_d;
      prow_q     <= prow_d;
      hrep_q     <= hrep_d;
      vrep_q     <= vrep_d;
      data_out_q <= data_out_d;
      valid_op_q <= valid_op_d;
      end_op_q   <= end_op_d;
    end
  end

  row_buffer #(.DEPTH(MP), .W(N)) u_row_buffer (
    .clk    (clk),
    .rst_n  (master_rst),
    .push   (accept),
    .rotate (rotate),
    .d      (data_in),
    .head   (head)
  );

  assign data_out = data_out_q;
  assign valid_op = valid_op_q;
  assign end_op   = end_op_q;

endmodule

// File: tb/tb_unpooler.sv
// Directed bench for unpooler with a scoreboard of expected outputs.
module tb_unpooler;

  localparam int MP = 4;
  localparam int P  = 3;

  typedef struct {
    logic [15:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        master_rst, ce, valid_ip;
  logic [15:0] data_in;
  logic        ready_ip, valid_op, end_op;
  logic [15:0] data_out;

  exp_t        q[$];
  int          total = 0, bad = 0;
  int          cyc = 0, n_cons = 0, n_idle = 0, n_ready = 0, end_cyc = -1;
  logic [15:0] last_exp = '0;

  unpooler #(.m(9'h00c), .p(9'h003), .N(16)) dut (
    .clk        (clk),
    .master_rst (master_rst),
    .ce         (ce),
    .data_in    (data_in),
    .valid_ip   (valid_ip),
    .ready_ip   (ready_ip),
    .data_out   (data_out),
    .valid_op   (valid_op),
    .end_op     (end_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected output stream of one map whose pooled values are base, base+1, ...
  task automatic push_map(input int base);
    exp_t x;
    for (int r = 0; r < MP; r++)
      for (int vr = 0; vr < P; vr++)
        for (int c = 0; c < MP; c++)
          for (int h = 0; h < P; h++) begin
            x.d = 16'(base + r * MP + c);
            x.e = (r == MP-1) && (vr == P-1) && (c == MP-1) && (h == P-1);
            q.push_back(x);
          end
  endtask

  // One clock: sample outputs on the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t x;
    @(negedge clk);
    if (ce) begin
      cyc++;
      if (ready_ip && !end_op) n_ready++;
      if (valid_op) begin
        n_cons++;
        if (q.size() == 0) chk("unexpected_output", 32'(valid_op), 32'(0));
        else begin
          x = q.pop_front();
          last_exp = x.d;
          chk("data_out", 32'(data_out), 32'(x.d));
          chk("end_op", 32'(end_op), 32'(x.e));
          if (end_op) end_cyc = cyc;
        end
      end else begin
        n_idle++;
        chk("end_op_idle", 32'(end_op), 32'(0));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    int n = 0;
    data_in  = 16'(v);
    valid_ip = 1'b1;
    while (!ready_ip && n < 300) begin tick(); n++; end
    chk("feed_ready", 32'(ready_ip), 32'(1));
    tick();
    valid_ip = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 400) begin tick(); n++; end
    chk("drain_empty", 32'(q.size()), 32'(0));
  endtask

  initial begin
    int s_cyc, s_idle, s_ready, s_cons;
    master_rst = 1'b0; ce = 1'b1; valid_ip = 1'b0; data_in = '0;

    // Reset values
    #1;
    chk("rst_data_out", 32'(data_out), 32'(0));
    chk("rst_valid_op", 32'(valid_op), 32'(0));
    chk("rst_end_op",   32'(end_op),   32'(0));
    repeat (2) @(posedge clk);
    #1 master_rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(ready_ip), 32'(1));
    chk("post_rst_valid", 32'(valid_op), 32'(0));
    ce = 1'b0; #1;
    chk("ready_ce_low", 32'(ready_ip), 32'(0));
    ce = 1'b1;
    tick();

    // Basic map: 1..16 with valid held
    push_map(1);
    s_ready = n_ready; s_cons = n_cons;
    feed(1);
    s_cyc = cyc; s_idle = n_idle;
    for (int v = 2; v <= 16; v++) feed(v);
    drain();
    chk("basic_outputs", 32'(n_cons - s_cons), 32'(144));
    chk("basic_no_gaps", 32'(n_idle - s_idle), 32'(0));
    chk("basic_end_pos", 32'(end_cyc - s_cyc), 32'(144));
    chk("basic_ready_cycles", 32'(n_ready - s_ready), 32'(16));

    // Bubble: two idle slots before input 2
    push_map(1);
    feed(1);
    s_cyc = cyc; s_idle = n_idle;
    begin
      int n = 0;
      while (!ready_ip && n < 50) begin tick(); n++; end
    end
    tick(); tick();
    for (int v = 2; v <= 16; v++) feed(v);
    drain();
    chk("bubble_idle", 32'(n_idle - s_idle), 32'(2));
    chk("bubble_end_pos", 32'(end_cyc - s_cyc), 32'(146));

    // ce stall in the middle of a replay row
    push_map(1);
    feed(1);
    s_cyc = cyc;
    for (int v = 2; v <= 4; v++) feed(v);
    repeat (5) tick();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data_hold", 32'(data_out), 32'(last_exp));
      chk("stall_valid_hold", 32'(valid_op), 32'(1));
      chk("stall_ready_low", 32'(ready_ip), 32'(0));
    end
    ce = 1'b1;
    for (int v = 5; v <= 16; v++) feed(v);
    drain();
    chk("stall_end_pos", 32'(end_cyc - s_cyc), 32'(144));

    // Back-to-back maps: next map's first value offered during end_op
    push_map(1);
    push_map(100);
    feed(1);
    s_idle = n_idle;
    for (int v = 2; v <= 16; v++) feed(v);
    data_in = 16'd100; valid_ip = 1'b1;
    begin
      int n = 0;
      while (!ready_ip && n < 300) begin tick(); n++; end
    end
    chk("b2b_ready_with_end", 32'(end_op), 32'(1));
    tick();
    valid_ip = 1'b0;
    chk("b2b_first_data", 32'(data_out), 32'(100));
    chk("b2b_first_valid", 32'(valid_op), 32'(1));
    for (int v = 101; v <= 115; v++) feed(v);
    drain();
    chk("b2b_no_gaps", 32'(n_idle - s_idle), 32'(0));

    // Mid-map reset during prow 1 replay
    push_map(1);
    for (int v = 1; v <= 8; v++) feed(v);
    repeat (5) tick();
    q.delete();
    master_rst = 1'b0;
    #1;
    chk("midrst_data_out", 32'(data_out), 32'(0));
    chk("midrst_valid_op", 32'(valid_op), 32'(0));
    chk("midrst_end_op",   32'(end_op),   32'(0));
    tick();
    master_rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(ready_ip), 32'(1));
    push_map(7);
    for (int v = 7; v <= 22; v++) feed(v);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
